// File: rtl/scanner_link_if.sv
// Signal bundle for scanner_link: sample input, peer flow control, serial output and status.
interface scanner_link_if #(
    parameter int unsigned DEPTH  = 10,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    logic              start;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_in;
    logic              peer_ready;
    logic              peer_half;
    logic              sclk_out;
    logic              sdata_out;
    logic [1:0]        state;
    logic [FILL_W-1:0] fill;
    logic              overflow;
    logic              xfer_done;

    modport master (
        output start, sample_valid, sample_in, peer_ready, peer_half,
        input  sclk_out, sdata_out, state, fill, overflow, xfer_done
    );

    modport slave (
        input  start, sample_valid, sample_in, peer_ready, peer_half,
        output sclk_out, sdata_out, state, fill, overflow, xfer_done
    );
endinterface

// File: rtl/scanner_link.sv
// Sample buffer with threshold command frames and an LSB-first serial link that
// drains the buffer to a downstream peer behind a CMD_DATA header.
module scanner_link #(
    parameter int unsigned DEPTH     = 10,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CMD_W     = 8,
    parameter int unsigned TH_READY  = 8,
    parameter int unsigned TH_START  = 9,
    parameter int unsigned CMD_READY = 2,
    parameter int unsigned CMD_START = 3,
    parameter int unsigned CMD_FULL  = 4,
    parameter int unsigned CMD_DATA  = 7
) (
    input  logic          clk,
    input  logic          rst,
    scanner_link_if.slave bus
);
    localparam int unsigned FILL_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned FRAME_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        STANDBY  = 2'd2,
        TRANSFER = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [FILL_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]           pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic                 xfer_done_q, xfer_done_d;
    logic                 hdr_sent_q, hdr_sent_d;
    logic                 abort_q, abort_d;
    logic                 busy_q, busy_d;
    logic                 sclk_q, sclk_d;
    logic                 sdata_q, sdata_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]     bits_left_q, bits_left_d;

    logic [DATA_W-1:0]    buf_q [DEPTH];

    logic                 wr_en_c;
    logic [FILL_W-1:0]    fill_inc_c;
    logic                 boundary_c;
    logic                 load_c;
    logic [FRAME_W-1:0]   load_word_c;
    logic [BIT_W-1:0]     load_last_c;
    logic                 finish_c;

    // Next-state: controller, fill tracking, frame arbitration and serializer.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        rd_ptr_d    = rd_ptr_q;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        xfer_done_d = 1'b0;
        hdr_sent_d  = hdr_sent_q;
        abort_d     = abort_q;
        busy_d      = busy_q;
        sclk_d      = sclk_q;
        sdata_d     = sdata_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        load_c      = 1'b0;
        load_word_c = '0;
        load_last_c = '0;
        finish_c    = 1'b0;

        wr_en_c    = bus.sample_valid && (state_q == ACTIVE) && (fill_q < FILL_W'(DEPTH));
        fill_inc_c = fill_q + FILL_W'(1);

        case (state_q)
            IDLE:     if (bus.start) state_d = ACTIVE;
            ACTIVE:   if (wr_en_c && (fill_inc_c == FILL_W'(DEPTH)))
                          state_d = bus.peer_ready ? TRANSFER : STANDBY;
            STANDBY:  if (bus.peer_ready || bus.peer_half) state_d = TRANSFER;
            TRANSFER: if (bus.peer_half) abort_d = 1'b1;
            default:  state_d = IDLE;
        endcase

        if (wr_en_c) begin
            fill_d = fill_inc_c;
            if (fill_inc_c == FILL_W'(TH_READY)) pending_d[0] = 1'b1;
            if (fill_inc_c == FILL_W'(TH_START)) pending_d[1] = 1'b1;
            if (fill_inc_c == FILL_W'(DEPTH))    pending_d[2] = 1'b1;
        end
        if (bus.sample_valid && !wr_en_c) overflow_d = 1'b1;

        // A boundary is either an idle link or the clock-high half of a frame's last bit.
        boundary_c = !busy_q || (sclk_q && (bits_left_q == '0));

        if (!boundary_c) begin
            if (!sclk_q) begin
                sclk_d = 1'b1;
            end else begin
                sclk_d      = 1'b0;
                sdata_d     = shift_q[0];
                shift_d     = shift_q >> 1;
                bits_left_d = bits_left_q - BIT_W'(1);
            end
        end else begin
            busy_d  = 1'b0;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
            if ((state_q == TRANSFER) && (abort_q || bus.peer_half)) begin
                finish_c = 1'b1;
            end else if (pending_q[0]) begin
                load_c       = 1'b1;
                load_word_c  = FRAME_W'(CMD_W'(CMD_READY));
                load_last_c  = BIT_W'(CMD_W - 1);
                pending_d[0] = 1'b0;
            end else if (pending_q[1]) begin
                load_c       = 1'b1;
                load_word_c  = FRAME_W'(CMD_W'(CMD_START));
                load_last_c  = BIT_W'(CMD_W - 1);
                pending_d[1] = 1'b0;
            end else if (pending_q[2]) begin
                load_c       = 1'b1;
                load_word_c  = FRAME_W'(CMD_W'(CMD_FULL));
                load_last_c  = BIT_W'(CMD_W - 1);
                pending_d[2] = 1'b0;
            end else if (state_q == TRANSFER) begin
                if (!hdr_sent_q) begin
                    load_c      = 1'b1;
                    load_word_c = FRAME_W'(CMD_W'(CMD_DATA));
                    load_last_c = BIT_W'(CMD_W - 1);
                    hdr_sent_d  = 1'b1;
                end else if (rd_ptr_q < fill_q) begin
                    load_c      = 1'b1;
                    load_word_c = FRAME_W'(buf_q[IDX_W'(rd_ptr_q)]);
                    load_last_c = BIT_W'(DATA_W - 1);
                    rd_ptr_d    = rd_ptr_q + FILL_W'(1);
                end else begin
                    finish_c = 1'b1;
                end
            end
        end

        if (load_c) begin
            busy_d      = 1'b1;
            sclk_d      = 1'b0;
            sdata_d     = load_word_c[0];
            shift_d     = load_word_c >> 1;
            bits_left_d = load_last_c;
        end

        if (finish_c) begin
            state_d     = IDLE;
            fill_d      = '0;
            rd_ptr_d    = '0;
            pending_d   = '0;
            hdr_sent_d  = 1'b0;
            abort_d     = 1'b0;
            xfer_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            rd_ptr_q    <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            xfer_done_q <= 1'b0;
            hdr_sent_q  <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            sclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            shift_q     <= '0;
            bits_left_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            rd_ptr_q    <= rd_ptr_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            xfer_done_q <= xfer_done_d;
            hdr_sent_q  <= hdr_sent_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            sclk_q      <= sclk_d;
            sdata_q     <= sdata_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
        end
    end

    // Sample storage; contents need no reset since fill gates every read.
    always_ff @(posedge clk) begin
        if (wr_en_c) buf_q[IDX_W'(fill_q)] <= bus.sample_in;
    end

    assign bus.sclk_out  = sclk_q;
    assign bus.sdata_out = sdata_q;
    assign bus.state     = state_q;
    assign bus.fill      = fill_q;
    assign bus.overflow  = overflow_q;
    assign bus.xfer_done = xfer_done_q;

endmodule
